// File: rtl/k12a_lcd_ctrl.sv
// k12a_lcd_ctrl -- HD44780-style character LCD sequencer.
//
// Runs the power-on initialisation sequence, then drains a small queue of
// command/data bytes written by the I/O register file. Each transfer drives
// lcd_rs/lcd_data, waits a setup time, strobes lcd_en, and then waits the
// LCD execution time before the next transfer may start.
//
// Ports:
//   cpu_clock  in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   cmd_valid  in   command byte offered this cycle
//   cmd_rs     in   0 = instruction, 1 = data
//   cmd_data   in   [7:0] byte to transfer
//   cmd_ready  out  queue not full
//   busy       out  sequencer active or queue non-empty
//   init_done  out  init sequence finished (sticky until reset)
//   lcd_rs     out  LCD register select
//   lcd_rw     out  LCD read/write, always write (0)
//   lcd_en     out  LCD enable strobe
//   lcd_data   out  [7:0] LCD data bus
module k12a_lcd_ctrl #(
  parameter int INIT_CYCLES  = 15000,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int EXEC_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       busy,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  // The shared down-counter is loaded with N-1 so a timed state lasts
  // exactly N cycles (it leaves on the cycle the counter reads zero).
  localparam logic [15:0] INIT_LOAD  = 16'(INIT_CYCLES - 1);
  localparam logic [15:0] SETUP_LOAD = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] EXEC_LOAD  = 16'(EXEC_CYCLES - 1);
  localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PWRWAIT,
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_EXEC
  } state_t;

  // Init ROM: function set (8-bit, 2 lines) twice, display on,
  // entry mode increment, clear.
  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_byte = 8'h38;
      3'd2:       init_byte = 8'h0C;
      3'd3:       init_byte = 8'h06;
      default:    init_byte = 8'h01;
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Command queue
  // ---------------------------------------------------------------------
  logic [8:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;
  logic [8:0]       head;

  assign cmd_ready = (count_reg != FULL_COUNT);
  assign push      = cmd_valid & cmd_ready;
  assign head      = fifo_mem[rd_ptr_reg];

  // Storage is not reset; a reset flush only clears the pointers.
  always_ff @(posedge cpu_clock) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {cmd_rs, cmd_data};
    end
  end

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------
  state_t      state_reg,     state_next;
  logic [15:0] cnt_reg,       cnt_next;
  logic [2:0]  init_idx_reg,  init_idx_next;
  logic        lcd_rs_reg,    lcd_rs_next;
  logic [7:0]  lcd_data_reg,  lcd_data_next;
  logic        lcd_en_reg,    lcd_en_next;
  logic        init_done_reg, init_done_next;
  logic        is_clear;

  // Clear display (0x01) and return home (0x02/0x03) need the long wait.
  assign is_clear = !lcd_rs_reg && (lcd_data_reg[7:2] == 6'd0) &&
                    (lcd_data_reg[1:0] != 2'd0);

  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_PWRWAIT;
      cnt_reg       <= INIT_LOAD;
      init_idx_reg  <= 3'd0;
      lcd_rs_reg    <= 1'b0;
      lcd_data_reg  <= 8'h00;
      lcd_en_reg    <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      init_idx_reg  <= init_idx_next;
      lcd_rs_reg    <= lcd_rs_next;
      lcd_data_reg  <= lcd_data_next;
      lcd_en_reg    <= lcd_en_next;
      init_done_reg <= init_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    init_idx_next  = init_idx_reg;
    lcd_rs_next    = lcd_rs_reg;
    lcd_data_next  = lcd_data_reg;
    init_done_next = init_done_reg;
    pop            = 1'b0;

    case (state_reg)
      ST_PWRWAIT: begin
        if (cnt_reg == 16'd0) begin
          state_next    = ST_INIT;
          init_idx_next = 3'd0;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      ST_INIT: begin
        lcd_rs_next   = 1'b0;
        lcd_data_next = init_byte(init_idx_reg);
        cnt_next      = SETUP_LOAD;
        state_next    = ST_SETUP;
      end

      // IDLE is only reachable after init completes, so the queue can
      // never be popped before init_done.
      ST_IDLE: begin
        if (count_reg != '0) begin
          pop           = 1'b1;
          lcd_rs_next   = head[8];
          lcd_data_next = head[7:0];
          cnt_next      = SETUP_LOAD;
          state_next    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        if (cnt_reg == 16'd0) begin
          cnt_next   = PULSE_LOAD;
          state_next = ST_PULSE;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      ST_PULSE: begin
        if (cnt_reg == 16'd0) begin
          cnt_next   = is_clear ? CLEAR_LOAD : EXEC_LOAD;
          state_next = ST_EXEC;
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      ST_EXEC: begin
        if (cnt_reg == 16'd0) begin
          if (init_done_reg) begin
            state_next = ST_IDLE;
          end else if (init_idx_reg == 3'd4) begin
            init_done_next = 1'b1;
            state_next     = ST_IDLE;
          end else begin
            init_idx_next = init_idx_reg + 3'd1;
            state_next    = ST_INIT;
          end
        end else begin
          cnt_next = cnt_reg - 16'd1;
        end
      end

      default: begin
        state_next = ST_PWRWAIT;
        cnt_next   = INIT_LOAD;
      end
    endcase

    // Registered strobe: glitch-free and high exactly while in PULSE.
    lcd_en_next = (state_next == ST_PULSE);
  end

  assign lcd_rs    = lcd_rs_reg;
  assign lcd_data  = lcd_data_reg;
  assign lcd_en    = lcd_en_reg;
  assign lcd_rw    = 1'b0;
  assign init_done = init_done_reg;
  assign busy      = (state_reg != ST_IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_k12a_lcd_ctrl.sv
// tb_k12a_lcd_ctrl -- directed self-checking bench for k12a_lcd_ctrl.
//
// Timing shorthand used below: with SETUP=1, PULSE=2, EXEC=3, CLEAR=8 a
// transfer popped/loaded at edge L shows lcd_en rising at L+1, falling at
// L+3 and the FSM back in IDLE/INIT at L+3+exec. Between two consecutive
// strobes lcd_en is therefore low for exec + 1 (load) + 1 (setup) cycles.
module tb_k12a_lcd_ctrl;

  logic       cpu_clock = 1'b0;
  logic       reset_n   = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_rs    = 1'b0;
  logic [7:0] cmd_data  = 8'h00;
  logic       cmd_ready;
  logic       busy;
  logic       init_done;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  k12a_lcd_ctrl #(
    .INIT_CYCLES (10),
    .SETUP_CYCLES(1),
    .PULSE_CYCLES(2),
    .EXEC_CYCLES (3),
    .CLEAR_CYCLES(8),
    .FIFO_DEPTH  (4)
  ) dut (
    .cpu_clock(cpu_clock),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_rs   (cmd_rs),
    .cmd_data (cmd_data),
    .cmd_ready(cmd_ready),
    .busy     (busy),
    .init_done(init_done),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data)
  );

  always #5 cpu_clock = ~cpu_clock;

  // Index of the most recent rising edge; read only at falling edges.
  int cyc = 0;
  always @(posedge cpu_clock) cyc <= cyc + 1;

  logic [7:0] init_seq [5] = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};

  // Strobe log, sampled shortly after each rising edge.
  int         n_pulse = 0;
  int         rise_cyc [64];
  int         fall_cyc [64];
  logic [7:0] p_data   [64];
  logic       p_rs     [64];
  logic       en_prev   = 1'b0;
  logic       done_prev = 1'b0;
  int         done_cyc  = -1;

  always begin
    @(posedge cpu_clock);
    #2;
    if (lcd_en && !en_prev && n_pulse < 64) begin
      rise_cyc[n_pulse] = cyc;
      fall_cyc[n_pulse] = -1;
      p_data[n_pulse]   = lcd_data;
      p_rs[n_pulse]     = lcd_rs;
      n_pulse           = n_pulse + 1;
    end
    if (!lcd_en && en_prev && n_pulse > 0) fall_cyc[n_pulse-1] = cyc;
    if (init_done && !done_prev) done_cyc = cyc;
    en_prev   = lcd_en;
    done_prev = init_done;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_pulse(input string tag, input int idx, input logic rs, input logic [7:0] d);
    check_eq($sformatf("%s_rs", tag), p_rs[idx], rs);
    check_eq($sformatf("%s_data", tag), p_data[idx], d);
    check_eq($sformatf("%s_width", tag), fall_cyc[idx] - rise_cyc[idx], 2);
  endtask

  // Called at a falling edge; offers one byte for the next rising edge.
  task automatic push_cmd(input logic rs, input logic [7:0] d, output logic acc, output int e);
    cmd_valid = 1'b1;
    cmd_rs    = rs;
    cmd_data  = d;
    acc       = cmd_ready;
    @(negedge cpu_clock);
    cmd_valid = 1'b0;
    e         = cyc;
    $display("[TB] push rs=%0d data=0x%02h ready=%0b edge=%0d", rs, d, acc, e);
  endtask

  task automatic wait_idle(input string tag, input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge cpu_clock);
      if (!busy) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) check_eq($sformatf("%s_timeout_busy", tag), busy, 1'b0);
    $display("[TB] %s idle at edge %0d", tag, at_cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000 time units, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rel;
    int   t;
    int   e;
    int   base;
    logic acc;

    // ---------------- reset values ----------------
    #1 reset_n = 1'b0;
    repeat (3) @(negedge cpu_clock);
    check_eq("rst_en",    lcd_en,    1'b0);
    check_eq("rst_rs",    lcd_rs,    1'b0);
    check_eq("rst_data",  lcd_data,  8'h00);
    check_eq("rst_rw",    lcd_rw,    1'b0);
    check_eq("rst_done",  init_done, 1'b0);
    check_eq("rst_busy",  busy,      1'b1);
    check_eq("rst_ready", cmd_ready, 1'b1);

    // ---------------- power-on init ----------------
    reset_n = 1'b1;
    rel     = cyc;
    base    = n_pulse;
    wait_idle("init", 200, t);
    check_eq("init_count", n_pulse - base, 5);
    for (int i = 0; i < 5; i++) check_pulse($sformatf("init%0d", i), base + i, 1'b0, init_seq[i]);
    // 10 power-wait + 1 load + 1 setup cycles before the first strobe
    check_eq("init_first_rise", rise_cyc[base] - rel, 12);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("init_gap%0d", i), rise_cyc[base+i+1] - fall_cyc[base+i], 5);
    check_eq("init_done_delay", done_cyc - fall_cyc[base+4], 8);
    check_eq("init_busy_fall", t, done_cyc);
    check_eq("init_done_level", init_done, 1'b1);
    check_eq("init_rw", lcd_rw, 1'b0);

    // ---------------- single data write ----------------
    base = n_pulse;
    push_cmd(1'b1, 8'h41, acc, e);
    check_eq("wr_accept", acc, 1'b1);
    check_eq("wr_busy", busy, 1'b1);
    check_eq("wr_hold_data", lcd_data, 8'h01);
    @(negedge cpu_clock);
    check_eq("wr_rs", lcd_rs, 1'b1);
    check_eq("wr_data", lcd_data, 8'h41);
    check_eq("wr_en_setup", lcd_en, 1'b0);
    wait_idle("wr", 50, t);
    check_eq("wr_rise", rise_cyc[base] - e, 2);
    check_pulse("wr", base, 1'b1, 8'h41);
    check_eq("wr_busy_cycles", t - e, 7);

    // ---------------- queue full ----------------
    base = n_pulse;
    push_cmd(1'b0, 8'h01, acc, e);   // clear: long EXEC to fill the queue
    while (cyc < e + 4) @(negedge cpu_clock);
    for (int k = 0; k < 6; k++) begin
      push_cmd(1'b1, 8'(k + 1), acc, t);
      check_eq($sformatf("qf_ready%0d", k), acc, (k < 4));
    end
    check_eq("qf_ready_full", cmd_ready, 1'b0);
    wait_idle("qf", 100, t);
    check_eq("qf_count", n_pulse - base, 5);
    check_pulse("qf0", base, 1'b0, 8'h01);
    for (int k = 1; k < 5; k++) check_pulse($sformatf("qf%0d", k), base + k, 1'b1, 8'(k));
    check_eq("qf_clear_gap", rise_cyc[base+1] - fall_cyc[base], 10);
    check_eq("qf_data01_gap", rise_cyc[base+2] - fall_cyc[base+1], 5);

    // ---------------- simultaneous push/pop ----------------
    base = n_pulse;
    push_cmd(1'b0, 8'h01, acc, e);
    while (cyc < e + 4) @(negedge cpu_clock);
    for (int k = 0; k < 4; k++) push_cmd(1'b1, 8'(8'h11 + k), acc, t);
    while (cyc < e + 12) @(negedge cpu_clock);
    push_cmd(1'b1, 8'h15, acc, t);   // same edge as the pop, queue full
    check_eq("pp_full_reject", acc, 1'b0);
    check_eq("pp_ready_after_pop", cmd_ready, 1'b1);
    while (cyc < e + 19) @(negedge cpu_clock);
    push_cmd(1'b1, 8'h16, acc, t);   // same edge as the pop, 3 entries
    check_eq("pp_accept3", acc, 1'b1);
    check_eq("pp_occ3_ready", cmd_ready, 1'b1);
    push_cmd(1'b1, 8'h17, acc, t);
    check_eq("pp_accept_last", acc, 1'b1);
    check_eq("pp_occ4_ready", cmd_ready, 1'b0);
    wait_idle("pp", 150, t);
    check_eq("pp_count", n_pulse - base, 7);
    check_pulse("pp0", base, 1'b0, 8'h01);
    for (int k = 0; k < 4; k++) check_pulse($sformatf("pp%0d", k + 1), base + 1 + k, 1'b1, 8'(8'h11 + k));
    check_pulse("pp5", base + 5, 1'b1, 8'h16);
    check_pulse("pp6", base + 6, 1'b1, 8'h17);

    // ---------------- clear/home detection ----------------
    base = n_pulse;
    push_cmd(1'b0, 8'h02, acc, e);
    push_cmd(1'b0, 8'h04, acc, t);
    wait_idle("clr", 100, t);
    check_eq("clr_count", n_pulse - base, 2);
    check_pulse("clr_home", base, 1'b0, 8'h02);
    check_pulse("clr_entry", base + 1, 1'b0, 8'h04);
    check_eq("clr_home_exec", rise_cyc[base+1] - fall_cyc[base], 10);
    check_eq("clr_entry_exec", t - fall_cyc[base+1], 3);

    // ---------------- reset during PULSE ----------------
    push_cmd(1'b1, 8'h55, acc, e);
    push_cmd(1'b1, 8'h66, acc, t);
    while (cyc < e + 2) @(negedge cpu_clock);
    check_eq("rp_en_before", lcd_en, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rp_en_async", lcd_en, 1'b0);
    check_eq("rp_data", lcd_data, 8'h00);
    check_eq("rp_done", init_done, 1'b0);
    check_eq("rp_busy", busy, 1'b1);
    check_eq("rp_ready", cmd_ready, 1'b1);
    @(negedge cpu_clock);
    @(negedge cpu_clock);
    reset_n = 1'b1;
    rel     = cyc;
    base    = n_pulse;
    wait_idle("reinit", 200, t);
    check_eq("reinit_count", n_pulse - base, 5);
    for (int i = 0; i < 5; i++) check_pulse($sformatf("reinit%0d", i), base + i, 1'b0, init_seq[i]);
    check_eq("reinit_first_rise", rise_cyc[base] - rel, 12);
    check_eq("reinit_done", init_done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/k12a_lcd_ctrl.md
# k12a_lcd_ctrl

Hardware sequencer for the HD44780-style character LCD on the k12a I/O port. Accepts queued command and data bytes from the I/O register file and performs the power-on initialisation sequence. Generates correctly timed lcd_rs/lcd_data/lcd_en cycles and enforces per-command execution delays, so software no longer bit-bangs enable or busy-waits.

## Interface

Parameters:
- INIT_CYCLES, 15000: power-on wait before the first init command.
- SETUP_CYCLES, 1: cycles rs/data are stable before lcd_en rises.
- PULSE_CYCLES, 1: lcd_en high width in cycles.
- EXEC_CYCLES, 40: post-pulse wait for ordinary commands and data.
- CLEAR_CYCLES, 1600: post-pulse wait for clear/home commands.
- FIFO_DEPTH, 4: command queue entries, power of two, at least 2.

Ports:
- cpu_clock, in, 1: system clock; all state changes on its rising edge.
- reset_n, in, 1: reset, asynchronous, active-low.
- cmd_valid, in, 1: a command byte is offered this cycle.
- cmd_rs, in, 1: 0 means instruction, 1 means data.
- cmd_data, in, 8: byte to transfer.
- cmd_ready, out, 1: queue can accept; high when not full.
- busy, out, 1: high when the FSM is not in IDLE or the queue is non-empty.
- init_done, out, 1: goes high once the init sequence completes; sticky until reset.
- lcd_rs, out, 1: LCD register select.
- lcd_rw, out, 1: constant 0 (write only).
- lcd_en, out, 1: LCD enable strobe.
- lcd_data, out, 8: LCD data bus.

All delay parameters are in the range 1 to 65535. A single 16-bit down-counter is shared by all timed states.

## Operation

- **Queue.** FIFO_DEPTH entries of {rs, data}.
  - Push on cmd_valid & cmd_ready.
  - Pop only from IDLE.
  - A push and pop in the same cycle are both honoured; occupancy is unchanged.
  - cmd_valid while full is ignored: no overwrite, no error.
  - Pointers wrap modulo FIFO_DEPTH. The occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
  - Pushes are accepted during init and drain after it.
- **States.**
  - PWRWAIT: counts INIT_CYCLES, then goes to INIT with init index 0.
  - INIT: loads the init ROM entry into the output registers (rs=0) and goes to SETUP. The ROM contents are 0x38, 0x38, 0x0C, 0x06, 0x01.
  - IDLE: if the queue is non-empty, pops the head into the output registers and goes to SETUP. Otherwise it stays in IDLE.
  - SETUP: lcd_en=0 for SETUP_CYCLES, then goes to PULSE.
  - PULSE: lcd_en=1 for PULSE_CYCLES, then goes to EXEC.
  - EXEC: lcd_en=0. It waits CLEAR_CYCLES if rs=0 and data[7:2]==0 and data[1:0]!=0 (clear/home); otherwise it waits EXEC_CYCLES.
  - EXEC exit: during init, the index increments and the FSM returns to INIT, or goes to IDLE and sets init_done after entry 4. Otherwise it goes to IDLE.
- lcd_rs and lcd_data are registered. They change only on a pop or init load and hold through SETUP, PULSE and EXEC.
- The FIFO is not popped before init_done.

## Timing

- **Reset values.**
  - lcd_en=0, lcd_rs=0, lcd_data=0x00, lcd_rw=0.
  - init_done=0, busy=1 (state PWRWAIT), cmd_ready=1.
  - Queue empty, state PWRWAIT.
- **Async reset mid-transfer.** lcd_en drops immediately without waiting for a clock. The queue is flushed and the init sequence restarts.
- **Per-transfer cycle count.** 1 (load) + SETUP + PULSE + EXEC cycles from leaving IDLE/INIT until returning.
  - Back-to-back queued commands: the next pop is at the first IDLE cycle, so there is 1 idle cycle between transfers.
- **Latency.** A push at edge E with the FSM in IDLE and the queue empty behaves as follows:
  - The queue is non-empty after E.
  - The pop at E+1 drives lcd_rs/lcd_data.
  - lcd_en is high from E+1+SETUP_CYCLES for PULSE_CYCLES cycles.
- **init_done.** Rises on the edge that moves from the final EXEC to IDLE.
- **busy.** Combinational from state and occupancy; low only in IDLE with the queue empty.

## Test plan

Bench parameters: INIT_CYCLES=10, SETUP=1, PULSE=2, EXEC=3, CLEAR=8, FIFO_DEPTH=4.

- **Reset and init.** Release reset, no commands. Required response:
  - lcd_en stays 0 for 10 cycles.
  - Then exactly 5 pulses, data 0x38, 0x38, 0x0C, 0x06, 0x01 with rs=0, each 2 cycles wide.
  - The gap after 0x01 is 8 cycles; the other gaps are 3 cycles.
  - init_done rises, then busy falls.
- **Single data write.** After init, push rs=1, data 0x41. Required response:
  - lcd_rs=1 and lcd_data=0x41 one cycle later.
  - lcd_en high for 2 cycles after 1 setup cycle.
  - busy low after 7 cycles total.
- **Queue full.** Push 6 back-to-back commands while the FSM is in EXEC, with values 0x01..0x06 as rs=1 data. Required response:
  - cmd_ready drops after 4 pushes; 0x05 and 0x06 are dropped.
  - Output order is 0x01..0x04.
- **Simultaneous push/pop.** Hold the queue at 4 entries and push on the cycle the FSM pops. Required response:
  - cmd_ready is low, so the push is rejected.
  - Repeat at 3 entries: the push is accepted and occupancy stays at 3.
- **Clear detection.** Push rs=0 0x02, then rs=0 0x04. Required response: EXEC lasts 8 cycles for 0x02 and 3 cycles for 0x04.
- **Reset during PULSE.** Assert reset_n low mid-pulse. Required response:
  - lcd_en goes to 0 with no clock edge.
  - After release, the queue is empty and the init sequence repeats from 0x38.
